// File: rtl/cond_logic_stage.sv
// Execute-stage conditional-execution unit: holds the NZCV flag register,
// evaluates the condition field against it, gates the E-stage control
// requests into the Memory stage and keeps saturating execute/skip counters.
module cond_logic_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ValidE,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic [3:0]       CondE,
    input  logic [3:0]       ALUFlagsE,
    input  logic [1:0]       FlagWriteE,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic             PCSrcE,
    input  logic             ClearCnt,
    output logic [3:0]       Flags,
    output logic             CondExE,
    output logic             PCSrcTakenE,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic             PCSrcM,
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SkipCnt
);

    logic [3:0]       r_flags;
    logic             r_regWriteM;
    logic             r_memWriteM;
    logic             r_pcSrcM;
    logic [CNT_W-1:0] r_execCnt;
    logic [CNT_W-1:0] r_skipCnt;

    logic             w_n;
    logic             w_z;
    logic             w_c;
    logic             w_v;
    logic             w_ge;
    logic             w_condEx;
    logic             w_act;
    logic             w_count;
    logic             w_execSat;
    logic             w_skipSat;

    assign w_n  = r_flags[3];
    assign w_z  = r_flags[2];
    assign w_c  = r_flags[1];
    assign w_v  = r_flags[0];
    assign w_ge = (w_n == w_v);

    // Condition decode works only from the registered flags, so a flag-setting
    // instruction affects the following instruction without any forwarding.
    always_comb begin
        w_condEx = 1'b0;
        case (CondE)
            4'b0000: w_condEx = w_z;
            4'b0001: w_condEx = ~w_z;
            4'b0010: w_condEx = w_c;
            4'b0011: w_condEx = ~w_c;
            4'b0100: w_condEx = w_n;
            4'b0101: w_condEx = ~w_n;
            4'b0110: w_condEx = w_v;
            4'b0111: w_condEx = ~w_v;
            4'b1000: w_condEx = w_c & ~w_z;
            4'b1001: w_condEx = ~(w_c & ~w_z);
            4'b1010: w_condEx = w_ge;
            4'b1011: w_condEx = ~w_ge;
            4'b1100: w_condEx = ~w_z & w_ge;
            4'b1101: w_condEx = ~(~w_z & w_ge);
            4'b1110: w_condEx = 1'b1;
            default: w_condEx = 1'b0;
        endcase
    end

    assign w_act     = ValidE & w_condEx & ~FlushE & ~StallE;
    assign w_count   = ValidE & ~FlushE & ~StallE;
    assign w_execSat = &r_execCnt;
    assign w_skipSat = &r_skipCnt;

    // Architectural flags: each half loads from the ALU only when the
    // instruction really retires here; the other half is held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flags <= 4'b0000;
        end else if (w_act) begin
            if (FlagWriteE[1]) begin
                r_flags[3:2] <= ALUFlagsE[3:2];
            end
            if (FlagWriteE[0]) begin
                r_flags[1:0] <= ALUFlagsE[1:0];
            end
        end
    end

    // E-to-M control register: a flush inserts a bubble even while stalled,
    // a stall holds, otherwise the requests pass gated by the condition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_regWriteM <= 1'b0;
            r_memWriteM <= 1'b0;
            r_pcSrcM    <= 1'b0;
        end else if (FlushE) begin
            r_regWriteM <= 1'b0;
            r_memWriteM <= 1'b0;
            r_pcSrcM    <= 1'b0;
        end else if (!StallE) begin
            r_regWriteM <= RegWriteE & w_condEx & ValidE;
            r_memWriteM <= MemWriteE & w_condEx & ValidE;
            r_pcSrcM    <= PCSrcE & w_condEx & ValidE;
        end
    end

    // Performance counters: clear beats increment, and both stick at all-ones
    // instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_execCnt <= '0;
            r_skipCnt <= '0;
        end else if (ClearCnt) begin
            r_execCnt <= '0;
            r_skipCnt <= '0;
        end else if (w_count) begin
            if (w_condEx && !w_execSat) begin
                r_execCnt <= r_execCnt + CNT_W'(1);
            end
            if (!w_condEx && !w_skipSat) begin
                r_skipCnt <= r_skipCnt + CNT_W'(1);
            end
        end
    end

    assign Flags       = r_flags;
    assign CondExE     = w_condEx;
    assign PCSrcTakenE = PCSrcE & w_condEx & ValidE & ~FlushE;
    assign RegWriteM   = r_regWriteM;
    assign MemWriteM   = r_memWriteM;
    assign PCSrcM      = r_pcSrcM;
    assign ExecCnt     = r_execCnt;
    assign SkipCnt     = r_skipCnt;

endmodule
